// File: rtl/mem_pkg.sv
// Shared definitions for the 32-bit memory built from two 16-bit SPRAM macros.
package mem_pkg;

    localparam int unsigned RamWordW = 32;
    localparam int unsigned RamHalfW = 16;
    localparam int unsigned RamAddrW = 14;

    typedef enum logic [1:0] {
        PortNone = 2'd0,
        PortI    = 2'd1,
        PortD    = 2'd2
    } port_e;

    typedef struct packed {
        logic [3:0] lo;
        logic [3:0] hi;
    } nib_mask_t;

    // Each byte strobe enables the two nibbles of that byte in its macro.
    function automatic nib_mask_t be_to_mask(input logic [3:0] be);
        nib_mask_t m;
        m.lo = {be[1], be[1], be[0], be[0]};
        m.hi = {be[3], be[3], be[2], be[2]};
        return m;
    endfunction

endpackage

// File: rtl/spram_bank32.sv
// 32-bit memory made of a lo (bits 15:0) and hi (bits 31:16) 16-bit SPRAM macro with
// nibble write masks and registered read data; driven by the arbiter's ram_* ports.
module spram_bank32
    import mem_pkg::*;
#(
    parameter int unsigned AW = 14
) (
    input  logic                clk,
    input  logic [RamAddrW-1:0] ram_addr,
    input  logic                ram_wren,
    input  logic [RamHalfW-1:0] ram_din_lo,
    input  logic [RamHalfW-1:0] ram_din_hi,
    input  logic [3:0]          ram_mask_lo,
    input  logic [3:0]          ram_mask_hi,
    output logic [RamHalfW-1:0] ram_dout_lo,
    output logic [RamHalfW-1:0] ram_dout_hi
);

    localparam int unsigned Depth = 2 ** AW;

    logic [AW-1:0]       idx;
    logic [RamHalfW-1:0] din  [2];
    logic [3:0]          mask [2];

    assign idx     = ram_addr[AW-1:0];
    assign din[0]  = ram_din_lo;
    assign din[1]  = ram_din_hi;
    assign mask[0] = ram_mask_lo;
    assign mask[1] = ram_mask_hi;

    if (AW < RamAddrW) begin : g_narrow
        logic unused_addr;
        assign unused_addr = ^ram_addr[RamAddrW-1:AW];
    end

    for (genvar h = 0; h < 2; h++) begin : g_macro
        logic [RamHalfW-1:0] mem [Depth];
        logic [RamHalfW-1:0] dout_q;

        // Read data holds across write cycles, like the macro's output latch.
        always_ff @(posedge clk) begin
            if (ram_wren) begin
                for (int n = 0; n < 4; n++) begin
                    if (mask[h][n]) begin
                        mem[idx][4*n +: 4] <= din[h][4*n +: 4];
                    end
                end
            end else begin
                dout_q <= mem[idx];
            end
        end
    end

    assign ram_dout_lo = g_macro[0].dout_q;
    assign ram_dout_hi = g_macro[1].dout_q;

endmodule

// File: rtl/spram_arbiter.sv
// Arbiter/sequencer sharing two 16-bit SPRAM macros between the I-fetch and load/store
// ports, with an optional zero-fill of the whole array after reset.
module spram_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned AW             = 14,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter bit          D_PRIORITY     = 1'b0
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                i_valid,
    input  logic [AW-1:0]       i_addr,
    output logic                i_ready,
    output logic                i_rvalid,
    output logic [RamWordW-1:0] i_rdata,
    input  logic                d_valid,
    input  logic                d_we,
    input  logic [AW-1:0]       d_addr,
    input  logic [RamWordW-1:0] d_wdata,
    input  logic [3:0]          d_be,
    output logic                d_ready,
    output logic                d_rvalid,
    output logic [RamWordW-1:0] d_rdata,
    output logic [RamAddrW-1:0] ram_addr,
    output logic                ram_wren,
    output logic [RamHalfW-1:0] ram_din_lo,
    output logic [RamHalfW-1:0] ram_din_hi,
    output logic [3:0]          ram_mask_lo,
    output logic [3:0]          ram_mask_hi,
    input  logic [RamHalfW-1:0] ram_dout_lo,
    input  logic [RamHalfW-1:0] ram_dout_hi,
    output logic                busy
);

    typedef enum logic {StClear, StServe} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
    port_e               rr_last_q, rr_last_d;
    port_e               rsp_src_q, rsp_src_d;
    logic                rsp_we_q, rsp_we_d;
    logic [RamAddrW-1:0] addr_q, addr_d;
    logic [RamWordW-1:0] i_rdata_q, i_rdata_d;
    logic [RamWordW-1:0] d_rdata_q, d_rdata_d;
    logic [RamWordW-1:0] rd_word;
    nib_mask_t           be_mask;

    assign be_mask = be_to_mask(d_be);

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rr_last_d   = rr_last_q;
        rsp_src_d   = PortNone;
        rsp_we_d    = 1'b0;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        busy        = 1'b0;
        ram_addr    = addr_q;
        ram_wren    = 1'b0;
        ram_din_lo  = d_wdata[15:0];
        ram_din_hi  = d_wdata[31:16];
        ram_mask_lo = be_mask.lo;
        ram_mask_hi = be_mask.hi;

        unique case (state_q)
            StClear: begin
                busy        = 1'b1;
                ram_wren    = 1'b1;
                ram_addr    = RamAddrW'(clr_cnt_q);
                ram_din_lo  = '0;
                ram_din_hi  = '0;
                ram_mask_lo = 4'hF;
                ram_mask_hi = 4'hF;
                clr_cnt_d   = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = StServe;
                end
            end
            StServe: begin
                if (i_valid && d_valid) begin
                    // Round-robin: the port that did not win last time takes the slot.
                    if (D_PRIORITY || rr_last_q != PortD) begin
                        d_ready = 1'b1;
                    end else begin
                        i_ready = 1'b1;
                    end
                end else begin
                    i_ready = i_valid;
                    d_ready = d_valid;
                end

                if (d_ready) begin
                    ram_addr  = RamAddrW'(d_addr);
                    ram_wren  = d_we;
                    rsp_src_d = PortD;
                    rsp_we_d  = d_we;
                    rr_last_d = PortD;
                end else if (i_ready) begin
                    ram_addr  = RamAddrW'(i_addr);
                    rsp_src_d = PortI;
                    rr_last_d = PortI;
                end
            end
        endcase

        addr_d = ram_addr;
    end

    always_comb begin
        rd_word   = {ram_dout_hi, ram_dout_lo};
        i_rvalid  = (rsp_src_q == PortI);
        d_rvalid  = (rsp_src_q == PortD);
        i_rdata_d = i_rvalid ? rd_word : i_rdata_q;
        d_rdata_d = (d_rvalid && !rsp_we_q) ? rd_word : d_rdata_q;
        i_rdata   = i_rdata_d;
        d_rdata   = d_rvalid ? (rsp_we_q ? '0 : rd_word) : d_rdata_q;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= CLEAR_ON_RESET ? StClear : StServe;
            clr_cnt_q <= '0;
            rr_last_q <= PortI;
            rsp_src_q <= PortNone;
            rsp_we_q  <= 1'b0;
            addr_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_last_q <= rr_last_d;
            rsp_src_q <= rsp_src_d;
            rsp_we_q  <= rsp_we_d;
            addr_q    <= addr_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: fill, table-driven arbitration/byte-write vectors, randomized
// traffic against a word-level model, and a priority/reset-mid-stream sequence.
module tb_spram_arbiter;
    import mem_pkg::*;

    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: fill enabled, round-robin.
    logic        resetb_a, i_valid_a, i_ready_a, i_rvalid_a, d_valid_a, d_we_a, d_ready_a;
    logic        d_rvalid_a, ram_wren_a, busy_a;
    logic [3:0]  i_addr_a, d_addr_a, d_be_a, mask_lo_a, mask_hi_a;
    logic [31:0] i_rdata_a, d_wdata_a, d_rdata_a;
    logic [13:0] ram_addr_a;
    logic [15:0] din_lo_a, din_hi_a, dout_lo_a, dout_hi_a;

    // Instance B: no fill, D priority.
    logic        resetb_b, i_valid_b, i_ready_b, i_rvalid_b, d_valid_b, d_we_b, d_ready_b;
    logic        d_rvalid_b, ram_wren_b, busy_b;
    logic [3:0]  i_addr_b, d_addr_b, d_be_b, mask_lo_b, mask_hi_b;
    logic [31:0] i_rdata_b, d_wdata_b, d_rdata_b;
    logic [13:0] ram_addr_b;
    logic [15:0] din_lo_b, din_hi_b, dout_lo_b, dout_hi_b;

    spram_arbiter #(.AW(AW), .CLEAR_ON_RESET(1'b1), .D_PRIORITY(1'b0)) u_dut_a (
        .clk(clk), .resetb(resetb_a),
        .i_valid(i_valid_a), .i_addr(i_addr_a), .i_ready(i_ready_a),
        .i_rvalid(i_rvalid_a), .i_rdata(i_rdata_a),
        .d_valid(d_valid_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
        .d_be(d_be_a), .d_ready(d_ready_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
        .ram_addr(ram_addr_a), .ram_wren(ram_wren_a),
        .ram_din_lo(din_lo_a), .ram_din_hi(din_hi_a),
        .ram_mask_lo(mask_lo_a), .ram_mask_hi(mask_hi_a),
        .ram_dout_lo(dout_lo_a), .ram_dout_hi(dout_hi_a), .busy(busy_a)
    );

    spram_bank32 #(.AW(AW)) u_bank_a (
        .clk(clk), .ram_addr(ram_addr_a), .ram_wren(ram_wren_a),
        .ram_din_lo(din_lo_a), .ram_din_hi(din_hi_a),
        .ram_mask_lo(mask_lo_a), .ram_mask_hi(mask_hi_a),
        .ram_dout_lo(dout_lo_a), .ram_dout_hi(dout_hi_a)
    );

    spram_arbiter #(.AW(AW), .CLEAR_ON_RESET(1'b0), .D_PRIORITY(1'b1)) u_dut_b (
        .clk(clk), .resetb(resetb_b),
        .i_valid(i_valid_b), .i_addr(i_addr_b), .i_ready(i_ready_b),
        .i_rvalid(i_rvalid_b), .i_rdata(i_rdata_b),
        .d_valid(d_valid_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_be(d_be_b), .d_ready(d_ready_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .ram_addr(ram_addr_b), .ram_wren(ram_wren_b),
        .ram_din_lo(din_lo_b), .ram_din_hi(din_hi_b),
        .ram_mask_lo(mask_lo_b), .ram_mask_hi(mask_hi_b),
        .ram_dout_lo(dout_lo_b), .ram_dout_hi(dout_hi_b), .busy(busy_b)
    );

    spram_bank32 #(.AW(AW)) u_bank_b (
        .clk(clk), .ram_addr(ram_addr_b), .ram_wren(ram_wren_b),
        .ram_din_lo(din_lo_b), .ram_din_hi(din_hi_b),
        .ram_mask_lo(mask_lo_b), .ram_mask_hi(mask_hi_b),
        .ram_dout_lo(dout_lo_b), .ram_dout_hi(dout_hi_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [3:0]  ia;
        logic        dv;
        logic        dwe;
        logic [3:0]  da;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        e_ir;
        logic        e_dr;
        logic        e_wren;
        logic [13:0] e_addr;
        logic [7:0]  e_mask;   // {hi, lo}
        logic        e_irv;
        logic        e_drv;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    // Word-level reference model for the randomized phase.
    logic [31:0] mm [16];
    bit          m_last_d;
    int          pend;       // 0 none, 1 I, 2 D
    logic [31:0] pend_data;
    logic [13:0] m_addr;
    logic        riv, rdv, rwe;
    logic [3:0]  ria, rda, rbe;
    logic [31:0] rwd;
    bit          gi, gd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required self-finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1, 5, 0, 0, 0, 32'h0,        4'h0, 1, 0, 0, 5, 8'h00, 1, 0, 32'h0};
        vecs[1]  = '{1, 7, 1, 1, 3, 32'h11223344, 4'hF, 0, 1, 1, 3, 8'hFF, 1, 0, 32'h0};
        vecs[2]  = '{1, 7, 1, 0, 3, 32'h0,        4'h0, 1, 0, 0, 7, 8'h00, 0, 1, 32'h0};
        vecs[3]  = '{1, 2, 1, 0, 3, 32'h0,        4'h0, 0, 1, 0, 3, 8'h00, 1, 0, 32'h0};
        vecs[4]  = '{1, 2, 1, 0, 3, 32'h0,        4'h0, 1, 0, 0, 2, 8'h00, 0, 1, 32'h11223344};
        vecs[5]  = '{0, 0, 1, 1, 3, 32'hAABBCCDD, 4'h5, 0, 1, 1, 3, 8'h33, 1, 0, 32'h0};
        vecs[6]  = '{0, 0, 0, 0, 0, 32'h0,        4'h0, 0, 0, 0, 3, 8'h00, 0, 1, 32'h0};
        vecs[7]  = '{0, 0, 1, 0, 3, 32'h0,        4'h0, 0, 1, 0, 3, 8'h00, 0, 0, 32'h0};
        vecs[8]  = '{0, 0, 1, 1, 3, 32'hFFFFFFFF, 4'h0, 0, 1, 1, 3, 8'h00, 0, 1, 32'h11BB33DD};
        vecs[9]  = '{0, 0, 1, 0, 3, 32'h0,        4'h0, 0, 1, 0, 3, 8'h00, 0, 1, 32'h0};
        vecs[10] = '{0, 0, 0, 0, 0, 32'h0,        4'h0, 0, 0, 0, 3, 8'h00, 0, 1, 32'h11BB33DD};

        resetb_a = 1'b0; i_valid_a = 1'b1; i_addr_a = 4'd5; d_valid_a = 1'b0; d_we_a = 1'b0;
        d_addr_a = '0; d_wdata_a = '0; d_be_a = '0;
        resetb_b = 1'b0; i_valid_b = 1'b0; i_addr_b = '0; d_valid_b = 1'b0; d_we_b = 1'b0;
        d_addr_b = '0; d_wdata_b = '0; d_be_b = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst i_ready", i_ready_a, 0);
        chk("rst rvalid", {i_rvalid_a, d_rvalid_a}, 0);
        chk("rst i_rdata", i_rdata_a, 0);
        chk("rst d_rdata", d_rdata_a, 0);
        chk("rst busy", busy_a, 1);

        // Zero-fill: 16 cycles, addresses 0..15, full masks, zero data, I held off.
        resetb_a = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk($sformatf("fill%0d busy", k), busy_a, 1);
            chk($sformatf("fill%0d addr", k), ram_addr_a, k);
            chk($sformatf("fill%0d wren", k), ram_wren_a, 1);
            chk($sformatf("fill%0d mask", k), {mask_hi_a, mask_lo_a}, 8'hFF);
            chk($sformatf("fill%0d din", k), {din_hi_a, din_lo_a}, 0);
            chk($sformatf("fill%0d i_ready", k), i_ready_a, 0);
            @(negedge clk);
        end
        #1;
        chk("fill end busy", busy_a, 0);
        chk("fill end i_ready", i_ready_a, 1);
        chk("fill end addr", ram_addr_a, 5);

        for (int r = 0; r < NV; r++) begin
            @(posedge clk); #1;
            i_valid_a = vecs[r].iv; i_addr_a = vecs[r].ia;
            d_valid_a = vecs[r].dv; d_we_a = vecs[r].dwe; d_addr_a = vecs[r].da;
            d_wdata_a = vecs[r].wd; d_be_a = vecs[r].be;
            @(negedge clk);
            chk($sformatf("vec%0d i_ready", r), i_ready_a, vecs[r].e_ir);
            chk($sformatf("vec%0d d_ready", r), d_ready_a, vecs[r].e_dr);
            chk($sformatf("vec%0d wren", r), ram_wren_a, vecs[r].e_wren);
            chk($sformatf("vec%0d addr", r), ram_addr_a, vecs[r].e_addr);
            if (vecs[r].e_wren) chk($sformatf("vec%0d mask", r), {mask_hi_a, mask_lo_a},
                                    vecs[r].e_mask);
            chk($sformatf("vec%0d i_rvalid", r), i_rvalid_a, vecs[r].e_irv);
            chk($sformatf("vec%0d d_rvalid", r), d_rvalid_a, vecs[r].e_drv);
            if (vecs[r].e_irv) chk($sformatf("vec%0d i_rdata", r), i_rdata_a, vecs[r].e_rdata);
            if (vecs[r].e_drv) chk($sformatf("vec%0d d_rdata", r), d_rdata_a, vecs[r].e_rdata);
        end

        // Randomized traffic against the model; state carried over from the table.
        for (int a = 0; a < 16; a++) mm[a] = '0;
        mm[3] = 32'h11BB33DD;
        m_last_d = 1'b1;
        pend = 0;
        pend_data = '0;
        m_addr = 14'd3;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            riv = ($urandom_range(0, 9) < 7);
            rdv = ($urandom_range(0, 9) < 7);
            rwe = $urandom_range(0, 1) == 1;
            ria = 4'($urandom_range(0, 15));
            rda = 4'($urandom_range(0, 15));
            rbe = 4'($urandom_range(0, 15));
            rwd = $urandom;
            i_valid_a = riv; i_addr_a = ria;
            d_valid_a = rdv; d_we_a = rwe; d_addr_a = rda; d_wdata_a = rwd; d_be_a = rbe;
            if (riv && rdv) begin
                gd = !m_last_d;
                gi = m_last_d;
            end else begin
                gi = riv;
                gd = rdv;
            end
            @(negedge clk);
            chk($sformatf("rnd%0d i_ready", c), i_ready_a, gi);
            chk($sformatf("rnd%0d d_ready", c), d_ready_a, gd);
            if (gd) begin
                chk($sformatf("rnd%0d addr", c), ram_addr_a, 14'(rda));
                chk($sformatf("rnd%0d wren", c), ram_wren_a, rwe);
            end else if (gi) begin
                chk($sformatf("rnd%0d addr", c), ram_addr_a, 14'(ria));
                chk($sformatf("rnd%0d wren", c), ram_wren_a, 0);
            end else begin
                chk($sformatf("rnd%0d idle addr", c), ram_addr_a, m_addr);
                chk($sformatf("rnd%0d idle wren", c), ram_wren_a, 0);
            end
            chk($sformatf("rnd%0d i_rvalid", c), i_rvalid_a, pend == 1);
            chk($sformatf("rnd%0d d_rvalid", c), d_rvalid_a, pend == 2);
            if (pend == 1) chk($sformatf("rnd%0d i_rdata", c), i_rdata_a, pend_data);
            if (pend == 2) chk($sformatf("rnd%0d d_rdata", c), d_rdata_a, pend_data);

            pend = 0;
            if (gd) begin
                m_last_d = 1'b1;
                m_addr = 14'(rda);
                pend = 2;
                if (rwe) begin
                    pend_data = '0;
                    for (int b = 0; b < 4; b++) begin
                        if (rbe[b]) mm[rda][8*b +: 8] = rwd[8*b +: 8];
                    end
                end else begin
                    pend_data = mm[rda];
                end
            end else if (gi) begin
                m_last_d = 1'b0;
                m_addr = 14'(ria);
                pend = 1;
                pend_data = mm[ria];
            end
        end
        @(posedge clk); #1;
        i_valid_a = 1'b0; d_valid_a = 1'b0;

        // D-priority instance: I starved while D is valid, granted once D drops.
        @(negedge clk);
        resetb_b = 1'b1;
        #1;
        chk("b busy", busy_b, 0);
        chk("b idle ready", {i_ready_b, d_ready_b}, 0);
        @(posedge clk); #1;
        i_valid_b = 1'b1; i_addr_b = 4'd9; d_valid_b = 1'b1; d_we_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            d_addr_b = 4'(k);
            @(negedge clk);
            chk($sformatf("prio%0d i_ready", k), i_ready_b, 0);
            chk($sformatf("prio%0d d_ready", k), d_ready_b, 1);
            @(posedge clk); #1;
        end
        d_valid_b = 1'b0;
        @(negedge clk);
        chk("prio drop i_ready", i_ready_b, 1);
        chk("prio drop ram_addr", ram_addr_b, 9);
        chk("prio last d_rvalid", d_rvalid_b, 1);
        @(posedge clk); #1;
        i_valid_b = 1'b0;
        @(negedge clk);
        chk("prio i_rvalid", i_rvalid_b, 1);
        chk("prio d_rvalid off", d_rvalid_b, 0);

        // Reset in the cycle after a D read grant drops the response.
        @(posedge clk); #1;
        d_valid_b = 1'b1; d_we_b = 1'b0; d_addr_b = 4'd2;
        @(negedge clk);
        chk("mid d_ready", d_ready_b, 1);
        @(posedge clk); #1;
        d_valid_b = 1'b0;
        resetb_b = 1'b0;
        @(negedge clk);
        chk("mid rst d_rvalid", d_rvalid_b, 0);
        @(posedge clk); #1;
        chk("mid rst d_rvalid2", d_rvalid_b, 0);
        i_valid_b = 1'b1; i_addr_b = 4'd4;
        @(negedge clk);
        resetb_b = 1'b1;
        #1;
        chk("post rst i_ready", i_ready_b, 1);
        chk("post rst addr", ram_addr_b, 4);
        @(negedge clk);
        chk("post rst i_rvalid", i_rvalid_b, 1);
        chk("post rst d_rvalid", d_rvalid_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
